// File: rtl/qpu_exu_wbck_arbiter_if.sv
// rtl/qpu_exu_wbck_arbiter_if.sv - ALU / long-pipe request and CRF write-port bundle for the write-back arbiter
interface qpu_exu_wbck_arbiter_if #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
);
  logic               alu_wbck_i_valid;
  logic               alu_wbck_i_ready;
  logic [XLEN-1:0]    alu_wbck_i_data;
  logic [RFIDX_W-1:0] alu_wbck_i_rdidx;

  logic               lng_wbck_i_valid;
  logic               lng_wbck_i_ready;
  logic [XLEN-1:0]    lng_wbck_i_data;
  logic [RFIDX_W-1:0] lng_wbck_i_rdidx;

  logic               crf_wbck_o_valid;
  logic               crf_wbck_o_ready;
  logic [XLEN-1:0]    crf_wbck_o_data;
  logic [RFIDX_W-1:0] crf_wbck_o_rdidx;
  logic               crf_wbck_o_src;

  modport master (
    input  alu_wbck_i_valid, alu_wbck_i_data, alu_wbck_i_rdidx,
    output alu_wbck_i_ready,
    input  lng_wbck_i_valid, lng_wbck_i_data, lng_wbck_i_rdidx,
    output lng_wbck_i_ready,
    output crf_wbck_o_valid, crf_wbck_o_data, crf_wbck_o_rdidx, crf_wbck_o_src,
    input  crf_wbck_o_ready
  );

  modport slave (
    output alu_wbck_i_valid, alu_wbck_i_data, alu_wbck_i_rdidx,
    input  alu_wbck_i_ready,
    output lng_wbck_i_valid, lng_wbck_i_data, lng_wbck_i_rdidx,
    input  lng_wbck_i_ready,
    input  crf_wbck_o_valid, crf_wbck_o_data, crf_wbck_o_rdidx, crf_wbck_o_src,
    output crf_wbck_o_ready
  );
endinterface

// File: rtl/qpu_exu_wbck_arbiter.sv
// rtl/qpu_exu_wbck_arbiter.sv - CRF write-port arbiter, long-pipe priority, one-entry output stage
// Optional ALU starvation guard enabled by defining QPU_WBCK_STARVE_GUARD_EN.
module qpu_exu_wbck_arbiter #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  qpu_exu_wbck_arbiter_if.master wb
);
  logic               slot_free;
  logic               alu_override;
  logic               lng_win;
  logic               alu_hs;
  logic               lng_hs;
  logic               load;
  logic [XLEN-1:0]    win_data;
  logic [RFIDX_W-1:0] win_rdidx;

  logic               out_valid;
  logic [XLEN-1:0]    out_data;
  logic [RFIDX_W-1:0] out_rdidx;
  logic               out_src;

  assign slot_free = ~out_valid | wb.crf_wbck_o_ready;

`ifdef QPU_WBCK_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign alu_override = (starve_cnt == CNT_W'(STARVE_MAX)) & wb.alu_wbck_i_valid;

  // Counts long-pipe grants taken while the ALU was waiting; frozen under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (slot_free) begin
      if (alu_hs | ~wb.alu_wbck_i_valid) begin
        starve_cnt <= '0;
      end else if (lng_hs && starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic [31:0] unused_starve_max;
  assign unused_starve_max = 32'(STARVE_MAX);
  assign alu_override      = 1'b0;
`endif

  // The ALU holds the grant whenever the long pipe does not, so its ready never waits on its own valid.
  assign lng_win             = wb.lng_wbck_i_valid & ~alu_override;
  assign wb.lng_wbck_i_ready = rst_n & lng_win & slot_free;
  assign wb.alu_wbck_i_ready = rst_n & ~lng_win & slot_free;

  assign alu_hs = wb.alu_wbck_i_valid & wb.alu_wbck_i_ready;
  assign lng_hs = wb.lng_wbck_i_valid & wb.lng_wbck_i_ready;

  assign win_data  = lng_win ? wb.lng_wbck_i_data  : wb.alu_wbck_i_data;
  assign win_rdidx = lng_win ? wb.lng_wbck_i_rdidx : wb.alu_wbck_i_rdidx;

  // Writes to x0 are accepted but never reach the register file.
  assign load = (alu_hs | lng_hs) & (win_rdidx != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rdidx <= '0;
      out_src   <= 1'b0;
    end else if (slot_free) begin
      out_valid <= load;
      if (load) begin
        out_data  <= win_data;
        out_rdidx <= win_rdidx;
        out_src   <= lng_win;
      end
    end
  end

  assign wb.crf_wbck_o_valid = out_valid;
  assign wb.crf_wbck_o_data  = out_data;
  assign wb.crf_wbck_o_rdidx = out_rdidx;
  assign wb.crf_wbck_o_src   = out_src;
endmodule
